// File: rtl/gbe_pkg.sv
// Shared definitions for the gigabit Ethernet datapath: transmit FSM encoding,
// frame/IFG defaults and statistics counter widths.
package gbe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DROP  = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

  localparam int unsigned DEF_MAX_FRAME_LEN = 1522;
  localparam int unsigned DEF_MIN_IFG       = 12;

  localparam int unsigned FRAME_CNT_W = 32;
  localparam int unsigned BYTE_CNT_W  = 32;
  localparam int unsigned ERR_CNT_W   = 16;
  localparam int unsigned IFG_CNT_W   = 16;
  localparam int unsigned LEN_W       = 16;
  localparam int unsigned GAP_W       = 16;

endpackage

// File: rtl/rgmii_oddr.sv
// Single-bit DDR output cell: rising-half value from a posedge register,
// falling-half value relaunched by a negedge register, selected by clock phase.
module rgmii_oddr (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rise_d_i,
  input  logic fall_d_i,
  output logic q_o
);

  logic rise_q;
  logic fall_pos_q;
  logic fall_neg_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q     <= 1'b0;
      fall_pos_q <= 1'b0;
    end else begin
      rise_q     <= rise_d_i;
      fall_pos_q <= fall_d_i;
    end
  end

  // Half-cycle retiming so the falling-half bit changes only at negedge.
  always_ff @(negedge clk_i) begin
    fall_neg_q <= fall_pos_q;
  end

  assign q_o = clk_i ? rise_q : fall_neg_q;

endmodule

// File: rtl/gmii_to_rgmii_tx.sv
// GMII (8-bit SDR) to RGMII (4-bit DDR) transmit converter with frame gating,
// oversize truncation via forced TX_ER, IFG monitoring and statistics.
module gmii_to_rgmii_tx
  import gbe_pkg::*;
#(
  parameter int unsigned MAX_FRAME_LEN = DEF_MAX_FRAME_LEN,
  parameter int unsigned MIN_IFG       = DEF_MIN_IFG
) (
  input  logic                   TXCLK_i,
  input  logic                   reset,
  input  logic [7:0]             GMII_TX_TXD_i,
  input  logic                   GMII_TX_EN_i,
  input  logic                   GMII_TX_ER_i,
  input  logic                   tx_enable_i,
  output logic                   TXC_o,
  output logic [3:0]             TXDATA_o,
  output logic                   TXCTL_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic [BYTE_CNT_W-1:0]  byte_cnt_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o,
  output logic [IFG_CNT_W-1:0]   ifg_viol_cnt_o,
  output logic                   busy_o
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_FRAME_LEN);
  localparam logic [GAP_W-1:0] MIN_G = GAP_W'(MIN_IFG);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [GAP_W-1:0] sat_gap(input logic [GAP_W-1:0] v);
    return (v >= MIN_G) ? MIN_G : v + GAP_W'(1);
  endfunction

  tx_state_e              state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   errored_q, errored_d;
  logic                   en_prev_q;
  logic                   busy_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [IFG_CNT_W-1:0]   viol_cnt_q, viol_cnt_d;

  logic       xmit;
  logic       forced;
  logic       frame_inc;
  logic       err_inc;
  logic       viol_inc;
  logic       start_edge;
  logic [3:0] rise_data, fall_data;
  logic       rise_ctl, fall_ctl;

  // A frame may only begin on a fresh TX_EN edge; this also ignores the
  // remainder of a frame that was interrupted by reset.
  assign start_edge = GMII_TX_EN_i & ~en_prev_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    gap_d     = gap_q;
    errored_d = errored_q;
    xmit      = 1'b0;
    forced    = 1'b0;
    frame_inc = 1'b0;
    err_inc   = 1'b0;
    viol_inc  = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (start_edge) begin
          if (state_q == ST_GAP && gap_q < MIN_G) viol_inc = 1'b1;
          if (tx_enable_i) begin
            state_d   = ST_FRAME;
            xmit      = 1'b1;
            len_d     = LEN_W'(1);
            errored_d = GMII_TX_ER_i;
          end else begin
            state_d = ST_DROP;
          end
        end else if (state_q == ST_GAP) begin
          if (gap_q == MIN_G) state_d = ST_IDLE;
          else                gap_d   = sat_gap(gap_q);
        end
      end
      ST_FRAME: begin
        if (GMII_TX_EN_i) begin
          xmit      = 1'b1;
          forced    = (len_q >= MAX_L);
          len_d     = sat_inc16(len_q);
          errored_d = errored_q | GMII_TX_ER_i | forced;
        end else begin
          state_d   = ST_GAP;
          gap_d     = GAP_W'(1);
          frame_inc = 1'b1;
          err_inc   = errored_q;
        end
      end
      ST_DROP: begin
        if (!GMII_TX_EN_i) begin
          state_d = ST_GAP;
          gap_d   = GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(frame_inc);
    byte_cnt_d  = byte_cnt_q + BYTE_CNT_W'(xmit);
    err_cnt_d   = err_inc  ? sat_inc16(err_cnt_q)  : err_cnt_q;
    viol_cnt_d  = viol_inc ? sat_inc16(viol_cnt_q) : viol_cnt_q;
  end

  always_ff @(posedge TXCLK_i) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      gap_q       <= '0;
      errored_q   <= 1'b0;
      en_prev_q   <= 1'b1;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      byte_cnt_q  <= '0;
      err_cnt_q   <= '0;
      viol_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      errored_q   <= errored_d;
      en_prev_q   <= GMII_TX_EN_i;
      busy_q      <= (state_d == ST_FRAME);
      frame_cnt_q <= frame_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      err_cnt_q   <= err_cnt_d;
      viol_cnt_q  <= viol_cnt_d;
    end
  end

  // Falling-half CTL carries TX_EN xor TX_ER; outside a transmitted byte
  // both halves are held at the idle encoding.
  always_comb begin
    rise_data = xmit ? GMII_TX_TXD_i[3:0] : 4'h0;
    fall_data = xmit ? GMII_TX_TXD_i[7:4] : 4'h0;
    rise_ctl  = xmit;
    fall_ctl  = xmit & ~(GMII_TX_ER_i | forced);
  end

  for (genvar b = 0; b < 4; b++) begin : g_data_oddr
    rgmii_oddr u_oddr (
      .clk_i    (TXCLK_i),
      .rst_i    (reset),
      .rise_d_i (rise_data[b]),
      .fall_d_i (fall_data[b]),
      .q_o      (TXDATA_o[b])
    );
  end

  rgmii_oddr u_ctl_oddr (
    .clk_i    (TXCLK_i),
    .rst_i    (reset),
    .rise_d_i (rise_ctl),
    .fall_d_i (fall_ctl),
    .q_o      (TXCTL_o)
  );

  assign TXC_o          = TXCLK_i;
  assign busy_o         = busy_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign byte_cnt_o     = byte_cnt_q;
  assign err_cnt_o      = err_cnt_q;
  assign ifg_viol_cnt_o = viol_cnt_q;

endmodule

// File: doc/gmii_to_rgmii_tx.md
# gmii_to_rgmii_tx

Transmit-side companion of the board's RGMII receive converter. It takes an 8-bit GMII frame stream from the MAC at 125 MHz and drives the 4-bit DDR RGMII pins toward the PHY. It also forwards the transmit clock, gates whole frames with an enable, truncates oversize frames with an error, and keeps frame, byte and error statistics for the control registers.

## Interface
Parameters:
- MAX_FRAME_LEN, 1522: maximum bytes per frame, counted from the first TX_EN byte.
- MIN_IFG, 12: minimum idle cycles between frames before a violation is counted.

Ports:
- TXCLK_i  in  1  125 MHz GMII transmit clock. Single clock for the block.
- reset  in  1  Synchronous, active-high reset.
- GMII_TX_TXD_i  in  8  MAC transmit data.
- GMII_TX_EN_i  in  1  MAC transmit enable.
- GMII_TX_ER_i  in  1  MAC transmit error.
- tx_enable_i  in  1  Frame gate. Sampled only at frame start.
- TXC_o  out  1  RGMII transmit clock, a copy of TXCLK_i, edge-aligned. The PHY adds the internal delay.
- TXDATA_o  out  4  RGMII DDR data.
- TXCTL_o  out  1  RGMII DDR control.
- frame_cnt_o  out  32  Frames transmitted. Wraps.
- byte_cnt_o  out  32  Bytes transmitted. Wraps.
- err_cnt_o  out  16  Frames carrying TX_ER, forced or from the MAC. Saturates at 16'hFFFF.
- ifg_viol_cnt_o  out  16  IFG violations. Saturates.
- busy_o  out  1  High while in FRAME.

## Operation
FSM states: IDLE, FRAME, DROP, GAP. Reset puts the FSM in IDLE.

- IDLE:
  - GMII_TX_EN_i=1 and tx_enable_i=1 -> FRAME. The byte is transmitted and len=1.
  - GMII_TX_EN_i=1 and tx_enable_i=0 -> DROP.
- FRAME:
  - Each TX_EN byte: len += 1, saturating at 16'hFFFF.
  - When len exceeds MAX_FRAME_LEN, every remaining byte of the frame goes out with the error encoding, and the frame is marked errored.
  - GMII_TX_EN_i falling -> GAP. On that cycle frame_cnt += 1, and err_cnt += 1 if the frame was marked errored.
  - A MAC TX_ER on any byte also marks the frame errored.
- DROP:
  - RGMII output is held idle (CTL=0, DATA=0) until GMII_TX_EN_i=0, then -> GAP.
  - Dropped frames increment no counter.
- GAP:
  - Counts idle cycles in gap, saturating at MIN_IFG.
  - TX_EN rising while gap < MIN_IFG: ifg_viol_cnt += 1, and the new frame is accepted normally (no stall).
  - gap == MIN_IFG -> IDLE.
  - From GAP, a new frame follows the same tx_enable_i rule as from IDLE.
- tx_enable_i falling mid-frame has no effect. The frame completes.
- byte_cnt += 1 for every transmitted byte, including forced-error bytes.
- Encoding per cycle:
  - Rising half: TXDATA=TXD[3:0], TXCTL=TX_EN.
  - Falling half: TXDATA=TXD[7:4], TXCTL=TX_EN XOR TX_ER_eff.
  - TX_ER_eff = GMII_TX_ER_i OR forced_error.
- Reset mid-frame: all outputs return to reset values on the next edge, with no tail bytes. Because GMII_TX_EN_i is still high after reset, the next frame is recognised only after TX_EN has been seen low for one cycle.

## Timing
- Reset values: TXDATA_o=0, TXCTL_o=0, all counters 0, busy_o=0. TXC_o keeps toggling.
- Latency:
  - GMII sampled at posedge N.
  - Low nibble and TX_EN appear on the pins from posedge N+1.
  - High nibble and CTL XOR appear from negedge N+1, launched by a negedge register loaded from the posedge pipeline register.
- Counters update on the posedge after the triggering GMII cycle. frame_cnt and err_cnt are visible one cycle after TX_EN falls.
- busy_o is registered and asserts the cycle after the first TX_EN byte.

## Structure
- Shared package gbe_pkg holds:
  - the FSM state encoding;
  - the MAX_FRAME_LEN and MIN_IFG defaults;
  - the counter widths.
- One sub-module, rgmii_oddr: a per-bit DDR output cell with a posedge register, a negedge register and a clock-phase output select, instantiated 5 times (4 data, 1 control).
- The FSM, counters and encoding live in gmii_to_rgmii_tx.

## Test plan
- 64-byte frame 0x00..0x3F with tx_enable=1:
  - pins show nibble pairs (0,0),(1,0)…(F,3) starting one cycle after TX_EN;
  - CTL is 1/1 on every cycle;
  - frame_cnt=1, byte_cnt=64, err_cnt=0.
- MAC TX_ER on byte 10: that cycle has CTL rising=1, falling=0; err_cnt=1.
- 1530-byte frame with MAX_FRAME_LEN=1522: bytes 1523–1530 are output with CTL 1/0; err_cnt=1; byte_cnt=1530.
- Two frames separated by 5 idle cycles: ifg_viol_cnt=1, frame_cnt=2, both frames transmitted intact.
- tx_enable=0 at frame start, then raised mid-frame: pins stay idle for the whole frame and frame_cnt is unchanged; the next frame transmits.
- Reset asserted at byte 20: the next edge gives TXDATA=0, TXCTL=0 and counters 0; a following frame transmits correctly once TX_EN has gone low.
